// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, mid-bit start qualification and framing check.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7 and drive parity_err.
module uart_rx #(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);
    localparam int BIT_CLOCKS  = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
    localparam int HALF_CLOCKS = BIT_CLOCKS / 2;
    localparam int CW          = $clog2(BIT_CLOCKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_t;

    state_t          r_state, w_next;
    logic            r_s1, r_s2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bits;
    logic [7:0]      r_shift;
    logic            w_tc, w_good, w_bad;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_tc   = (r_cnt == CW'(BIT_CLOCKS - 1));
        w_next = r_state;
        w_good = 1'b0;
        w_bad  = 1'b0;
        case (r_state)
            S_IDLE:   if (!r_s2) w_next = S_START;
            S_START: begin
                w_tc = (r_cnt == CW'(HALF_CLOCKS - 1));
                if (w_tc) w_next = r_s2 ? S_IDLE : S_DATA;
            end
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_tc && r_bits == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_tc) w_next = S_STOP;
`else
            S_DATA:   if (w_tc && r_bits == 3'd7) w_next = S_STOP;
`endif
            S_STOP: if (w_tc) begin
                w_good = r_s2;
                w_bad  = !r_s2;
                w_next = r_s2 ? S_IDLE : S_WAIT;
            end
            S_WAIT:   if (r_s2) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_s1       <= rx;
            r_s2       <= r_s1;
            r_cnt      <= (r_state == S_IDLE || w_next != r_state || w_tc) ? '0 : r_cnt + 1'b1;
            data_valid <= w_good;
            frame_err  <= w_bad;
            if (w_good) data <= r_shift;
            // the 3-bit counter wraps 7 -> 0 as the last data bit is shifted in
            if (r_state == S_DATA && w_tc) begin
                r_shift <= {r_s2, r_shift[7:1]};
                r_bits  <= r_bits + 1'b1;
            end
        end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_par      <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_tc) r_par <= r_s2;
            parity_err <= w_good & (^r_shift ^ r_par);
        end
`else
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at BIT_CLOCKS=10, HALF_CLOCKS=5.
// Frames are built bit-by-bit from the line format; expected events come from a simple frame-level model.
module tb_uart_rx;
    localparam int CLK_KHZ = 1000;
    localparam int BAUD    = 100000;
    localparam int BITC    = 10;
    localparam int HALFC   = 5;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LAT = 2 + HALFC + (NB - 1) * BITC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, rx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ_KHz(CLK_KHZ), .BAUD_RATE_BPS(BAUD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
        .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy)
    );

    typedef struct {
        bit         fe;
        logic [7:0] d;
        logic       pe;
        time        t;
    } ev_t;

    ev_t  evq[$];
    int   viol = 0;
    int   perr_cnt = 0;
    logic prev_dv = 1'b0, prev_fe = 1'b0;

    always @(negedge clk) begin
        if (data_valid === 1'b1 || frame_err === 1'b1)
            evq.push_back('{frame_err === 1'b1, data, parity_err, $time});
        if ((data_valid === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe) ||
            (data_valid === 1'b1 && frame_err === 1'b1) || (parity_err === 1'b1 && data_valid !== 1'b1))
            viol++;
        if (parity_err === 1'b1) perr_cnt++;
        prev_dv = (data_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    // called and returns on a falling clock edge so frames can be chained with no gap
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, output time t0);
        logic fb[11];
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i + 1] = b[i];
`ifdef UART_RX_PARITY_EN
        fb[9]  = par;
        fb[10] = stop;
`else
        fb[9]  = stop;
        fb[10] = par;
`endif
        t0 = $time;
        for (int i = 0; i < NB; i++) begin
            rx = fb[i];
            repeat (BITC) @(negedge clk);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({data, data_valid, frame_err, parity_err, rx_busy} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h dv=%b fe=%b pe=%b busy=%b want all 0",
                     data, data_valid, frame_err, parity_err, rx_busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b0 || evq.size() != 0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b events=%0d want 0/0", rx_busy, evq.size());
        end
    endtask

    task automatic test_good_frame;
        time t0;
        int  lat;
        evq.delete();
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (evq.size() != 1) begin
            n_bad++;
            $display("FAIL good_count: got %0d events want 1", evq.size());
        end else begin
            lat = int'((evq[0].t - t0) / 10);
            n_cmp++;
            if (evq[0].fe || evq[0].d !== 8'hA5) begin
                n_bad++;
                $display("FAIL good_event: got fe=%b data=%h want fe=0 data=a5", evq[0].fe, evq[0].d);
            end
            n_cmp++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                n_bad++;
                $display("FAIL good_latency: got %0d cycles want %0d+-1", lat, LAT);
            end
        end
        n_cmp++;
        if (data !== 8'hA5) begin
            n_bad++;
            $display("FAIL good_data_hold: got %h want a5", data);
        end
    endtask

    task automatic test_glitch;
        bit seen = 0;
        evq.delete();
        rx = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rx_busy === 1'b1) seen = 1;
        end
        rx = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rx_busy === 1'b1) seen = 1;
        end
        check_bit("glitch_busy_seen", seen, 1'b1);
        check_bit("glitch_busy_end", rx_busy, 1'b0);
        n_cmp++;
        if (evq.size() != 0 || data !== 8'hA5) begin
            n_bad++;
            $display("FAIL glitch_no_output: got events=%0d data=%h want 0/a5", evq.size(), data);
        end
    endtask

    task automatic test_frame_err;
        time t0;
        bit  busy_ok = 1;
        evq.delete();
        send_frame(8'h3C, 1'b0, ^8'h3C, t0);
        repeat (30) begin
            @(negedge clk);
            if (rx_busy !== 1'b1) busy_ok = 0;
        end
        check_bit("ferr_busy_held", busy_ok, 1'b1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check_bit("ferr_busy_release", rx_busy, 1'b0);
        n_cmp++;
        if (evq.size() != 1 || !evq[0].fe || evq[0].pe !== 1'b0) begin
            n_bad++;
            $display("FAIL ferr_event: got events=%0d want one frame_err without parity_err", evq.size());
        end
        n_cmp++;
        if (data !== 8'hA5) begin
            n_bad++;
            $display("FAIL ferr_data_hold: got %h want a5", data);
        end
    endtask

    task automatic test_back_to_back;
        time t0, t1;
        evq.delete();
        send_frame(8'h00, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 1'b1, 1'b0, t1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (evq.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d events want 2", evq.size());
        end else begin
            n_cmp++;
            if (evq[0].fe || evq[1].fe || evq[0].d !== 8'h00 || evq[1].d !== 8'hFF) begin
                n_bad++;
                $display("FAIL b2b_data: got %h,%h want 00,ff", evq[0].d, evq[1].d);
            end
            n_cmp++;
            if (evq[1].t - evq[0].t != time'(NB * BITC * 10)) begin
                n_bad++;
                $display("FAIL b2b_spacing: got %0t want %0d cycles", evq[1].t - evq[0].t, NB * BITC);
            end
        end
    endtask

    task automatic test_random;
        ev_t        exp_q[$];
        logic [7:0] last = data;
        time        t0;
        evq.delete();
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic       stop, par;
            int         gap;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = (^b) ^ ($urandom_range(0, 2) == 0);
            gap  = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(3, 6));
            send_frame(b, stop, par, t0);
            if (stop) begin
                last = b;
`ifdef UART_RX_PARITY_EN
                exp_q.push_back('{1'b0, b, (^b) ^ par, 0});
`else
                exp_q.push_back('{1'b0, b, 1'b0, 0});
`endif
            end else
                exp_q.push_back('{1'b1, last, 1'b0, 0});
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (evq.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else
            foreach (exp_q[i]) begin
                n_cmp++;
                if (evq[i].fe != exp_q[i].fe || evq[i].d !== exp_q[i].d || evq[i].pe !== exp_q[i].pe) begin
                    n_bad++;
                    $display("FAIL rand_ev%0d: got fe=%b d=%h pe=%b want fe=%b d=%h pe=%b", i,
                             evq[i].fe, evq[i].d, evq[i].pe, exp_q[i].fe, exp_q[i].d, exp_q[i].pe);
                end
            end
        n_cmp++;
        if (data !== last) begin
            n_bad++;
            $display("FAIL rand_data_hold: got %h want %h", data, last);
        end
    endtask

    task automatic test_async_reset;
        time t0;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check_bit("arst_busy_before", rx_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({data, data_valid, frame_err, parity_err, rx_busy} !== 12'h000) begin
            n_bad++;
            $display("FAIL arst_immediate: got data=%h dv=%b fe=%b pe=%b busy=%b want all 0",
                     data, data_valid, frame_err, parity_err, rx_busy);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        evq.delete();
        send_frame(8'h5A, 1'b1, 1'b0, t0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (evq.size() != 1 || data !== 8'h5A) begin
            n_bad++;
            $display("FAIL arst_recover: got events=%0d data=%h want 1/5a", evq.size(), data);
        end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        time t0;
        evq.delete();
        send_frame(8'h07, 1'b1, 1'b0, t0);
        send_frame(8'h07, 1'b1, 1'b1, t0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (evq.size() != 2) begin
            n_bad++;
            $display("FAIL parity_count: got %0d events want 2", evq.size());
        end else begin
            check_bit("parity_bad_flag", evq[0].pe, 1'b1);
            check_bit("parity_good_flag", evq[1].pe, 1'b0);
            n_cmp++;
            if (evq[0].d !== 8'h07 || evq[1].d !== 8'h07) begin
                n_bad++;
                $display("FAIL parity_data: got %h,%h want 07,07", evq[0].d, evq[1].d);
            end
        end
`else
        n_cmp++;
        if (perr_cnt != 0) begin
            n_bad++;
            $display("FAIL parity_tied: got %0d parity_err cycles want 0", perr_cnt);
        end
`endif
    endtask

    task automatic test_pulse_rules;
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL pulse_rules: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_random;
        test_async_reset;
        test_parity;
        test_pulse_rules;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter, using the same frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line.
- Synchronizes the asynchronous `rx` pin, qualifies the start bit at mid-bit, and samples each data bit at its centre.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.
- Sits at the FPGA pin boundary, feeding a byte-stream consumer.

Parameters:
- CLK_FREQ_KHz, 50000, system clock frequency in kHz.
- BAUD_RATE_BPS, 115200, line rate in bits per second.
- BIT_CLOCKS (local, not overridable), (CLK_FREQ_KHz*1000)/BAUD_RATE_BPS with integer division, clock cycles per bit; must be >= 4.
- HALF_CLOCKS (local), BIT_CLOCKS/2 with integer division.

Ports:
- clk  in  1  system clock; one clock domain, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line from the pin; asynchronous to clk; idles high.
- data  out  8  last correctly framed byte; holds its value until the next good frame.
- data_valid  out  1  one-cycle pulse when `data` is updated.
- frame_err  out  1  one-cycle pulse when a sampled stop bit is 0.
- parity_err  out  1  one-cycle parity-mismatch pulse; tied to 0 unless UART_RX_PARITY_EN is defined.
- rx_busy  out  1  high whenever the state machine is not in Idle.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - data=0x00; data_valid=0; frame_err=0; parity_err=0; rx_busy=0.
  - Both synchronizer flops=1; state=Idle; bit-clock counter=0; data-bit counter=0; shift register=0.
- Synchronizer: `rx` passes through 2 flops to give rx_s. All decisions use rx_s; raw `rx` is never used directly.
- Bit-clock counter:
  - Width clog2(BIT_CLOCKS); increments by 1 each cycle.
  - Clears to 0 on every state change and on reaching its terminal count.
- States:
  - Idle: counters=0. rx_s==0 -> StartBit.
  - StartBit: count 0..HALF_CLOCKS-1. At count HALF_CLOCKS-1:
    - rx_s==0 -> DataBits.
    - rx_s==1 -> Idle. This is glitch rejection: no output pulse.
  - DataBits: at count BIT_CLOCKS-1:
    - Shift the register right, loading rx_s into bit 7.
    - If data-bit counter==7: clear it -> StopBit (ParityBit when the feature is enabled).
    - Otherwise: increment the data-bit counter.
  - ParityBit (feature only): at count BIT_CLOCKS-1, capture rx_s as the received parity bit -> StopBit.
  - StopBit: at count BIT_CLOCKS-1:
    - rx_s==1: data<=shift register; data_valid=1 for 1 cycle -> Idle.
    - rx_s==0: frame_err=1 for 1 cycle; data unchanged -> WaitIdle.
  - WaitIdle: stay until rx_s==1 -> Idle. Prevents a break condition or line-low from retriggering a start.
- Latency: data_valid rises 2 + HALF_CLOCKS + 9*BIT_CLOCKS (+1 if any) cycles after the falling edge at `rx`. The bench checks ±1 cycle.
- Back-to-back frames: the next start bit is accepted on the first Idle cycle, so a single stop bit between frames is sufficient.
- Pulses: data_valid, frame_err and parity_err are never high on consecutive cycles for the same frame. data_valid and frame_err are mutually exclusive.
- Reset mid-frame: the partial frame is discarded and no pulse is produced. Resynchronization afterwards relies on line idle; the bench does not check bytes that straddle the reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7, using the ParityBit state.
  - parity_err = (XOR of the 8 data bits) XOR (received parity bit).
  - parity_err pulses in the same cycle as data_valid. data is still updated.
  - Parity is not checked on frames that fail framing.
- Undefined:
  - ParityBit state absent; frame is 10 bits.
  - parity_err is constant 0.

Test Plan (CLK_FREQ_KHz=1000, BAUD_RATE_BPS=100000 -> BIT_CLOCKS=10, HALF_CLOCKS=5):
- Good frame: send 0xA5 with stop=1 -> data=0xA5; data_valid high exactly 1 cycle at 97±1 cycles after the falling edge; frame_err=0.
- Glitch: rx low for 3 cycles in Idle -> rx_busy pulses briefly and returns to 0; no data_valid or frame_err; data unchanged.
- Framing error: send 0x3C with stop=0, then hold rx low 30 cycles -> frame_err 1 cycle; data stays 0xA5; rx_busy high until rx returns to 1.
- Back-to-back: 0x00 then 0xFF with one stop bit each -> two data_valid pulses 100 cycles apart; data=0x00 then 0xFF.
- Async reset: assert rst during DataBits, between clock edges -> all outputs 0 immediately; release, send 0x5A -> data=0x5A.
- Parity (macro defined): send 0x07 with parity bit 0 -> data=0x07, data_valid and parity_err pulse together. Send 0x07 with parity bit 1 -> parity_err=0.
